// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone bus arbiter slice.
// Imported by the arbiter top and its timeout counter.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    localparam int WB_DEFAULT_TIMEOUT = 1024;
    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    typedef struct packed {
        logic               cyc;
        logic               stb;
        logic               we;
        logic [WB_DW/8-1:0] wstrb;
        logic [WB_AW-1:0]   addr;
        logic [WB_DW-1:0]   data;
    } wb_req_t;

    typedef struct packed {
        logic [WB_DW-1:0] data;
        logic             ack;
        logic             err;
    } wb_rsp_t;

endpackage

// File: rtl/wb_timeout_counter.sv
// Per-transaction watchdog: counts strobed cycles without ack and
// flags when the granted access has waited its full budget.
module wb_timeout_counter
    import wb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = WB_DEFAULT_TIMEOUT,
    parameter int TIMEOUT_CW     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int CW = (TIMEOUT_CW < 1) ? 1 : TIMEOUT_CW;
    localparam int LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] LAST = CW'(LAST_I);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    // A zero budget disables the watchdog entirely.
    assign expired = (TIMEOUT_CYCLES != 0) && (cnt == LAST);

endmodule

// File: rtl/wb_bus_arbiter.sv
// 2:1 round-robin Wishbone-classic arbiter sharing one core bus
// between the instruction (m0) and data (m1) masters.
module wb_bus_arbiter
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = WB_DEFAULT_TIMEOUT,
    parameter int TIMEOUT_CW     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                    sys_clk,
    input  logic                    rst_n,

    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb_i,
    input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_data_i,
    output logic [DATA_WIDTH-1:0]   m0_data_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,

    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb_i,
    input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_data_i,
    output logic [DATA_WIDTH-1:0]   m1_data_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,

    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_wstrb_o,
    output logic [ADDR_WIDTH-1:0]   s_addr_o,
    output logic [DATA_WIDTH-1:0]   s_data_o,
    input  logic [DATA_WIDTH-1:0]   s_data_i,
    input  logic                    s_ack_i,

    output logic [1:0]              grant_o
);

    arb_state_t state;
    logic       prio;
    logic       req0, req1;
    logic       g0, g1;
    logic       ack_fwd, tmo, expired;
    logic       cnt_clr, cnt_inc;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;
    assign g0   = (state == GRANT0);
    assign g1   = (state == GRANT1);

    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_wstrb_o = '0;
        s_addr_o  = '0;
        s_data_o  = '0;
        unique case (1'b1)
            g0: begin
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i;
                s_we_o    = m0_we_i;
                s_wstrb_o = m0_wstrb_i;
                s_addr_o  = m0_addr_i;
                s_data_o  = m0_data_i;
            end
            g1: begin
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i;
                s_we_o    = m1_we_i;
                s_wstrb_o = m1_wstrb_i;
                s_addr_o  = m1_addr_i;
                s_data_o  = m1_data_i;
            end
            default: ;
        endcase
    end

    // A master that dropped cyc never sees a late ack or err.
    assign ack_fwd = s_cyc_o & s_ack_i;
    assign tmo     = s_cyc_o & ~s_ack_i & expired;

    assign m0_ack_o  = g0 & ack_fwd;
    assign m1_ack_o  = g1 & ack_fwd;
    assign m0_err_o  = g0 & tmo;
    assign m1_err_o  = g1 & tmo;
    assign m0_data_o = s_data_i;
    assign m1_data_o = s_data_i;
    assign grant_o   = {g1, g0};

    assign cnt_clr = ~(g0 | g1) | s_ack_i | tmo;
    assign cnt_inc = (g0 | g1) & s_stb_o & ~s_ack_i;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_CW     (TIMEOUT_CW)
    ) u_tmo (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .expired (expired)
    );

    // prio=0 favours m0 when both request from IDLE.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            prio  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 && (!req1 || !prio)) begin
                        state <= GRANT0;
                    end else if (req1) begin
                        state <= GRANT1;
                    end
                end
                GRANT0: begin
                    if (!m0_cyc_i) begin
                        state <= IDLE;
                    end else if (s_ack_i) begin
                        prio  <= 1'b1;
                        state <= req1 ? GRANT1 : (req0 ? GRANT0 : IDLE);
                    end else if (tmo) begin
                        prio  <= 1'b1;
                        state <= IDLE;
                    end
                end
                GRANT1: begin
                    if (!m1_cyc_i) begin
                        state <= IDLE;
                    end else if (s_ack_i) begin
                        prio  <= 1'b0;
                        state <= req0 ? GRANT0 : (req1 ? GRANT1 : IDLE);
                    end else if (tmo) begin
                        prio  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- 2:1 Wishbone-classic arbiter that shares the single core memory bus between an instruction master (m0) and a data master (m1).
- Used when ENABLE_SECOND_MEMORY is not defined, so that split-port cores can reach the Controller through the one core_* bus.
- Round-robin fairness, registered grant, zero-latency return path, and a per-transaction timeout watchdog that returns err instead of hanging the core.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 1024, cycles a granted transaction may wait for s_ack_i before it is aborted; 0 disables the watchdog
- TIMEOUT_CW, $clog2(TIMEOUT_CYCLES+1), timeout counter width (derived)

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- m0_cyc_i, m0_stb_i, m0_we_i  in  1 each  instruction master request
- m0_wstrb_i  in  DATA_WIDTH/8  byte strobes
- m0_addr_i  in  ADDR_WIDTH  address
- m0_data_i  in  DATA_WIDTH  write data
- m0_data_o  out  DATA_WIDTH  read data
- m0_ack_o, m0_err_o  out  1 each  completion / timeout error
- m1_*  same set as m0_*  data master
- s_cyc_o, s_stb_o, s_we_o  out  1 each  shared bus request
- s_wstrb_o  out  DATA_WIDTH/8
- s_addr_o  out  ADDR_WIDTH
- s_data_o  out  DATA_WIDTH
- s_data_i  in  DATA_WIDTH
- s_ack_i  in  1
- grant_o  out  2  one-hot current grant, for debug

Behaviour:
- Clock and reset: one clock, sys_clk. rst_n is asynchronous and active-low.
- Reset state: state IDLE, grant_o=00, priority pointer = m0, timeout counter = 0.
- Reset values of outputs: s_cyc_o, s_stb_o, s_we_o and all acks/errs are 0. s_addr_o, s_data_o, s_wstrb_o are 0.
- States: IDLE, GRANT0, GRANT1. The state register is the only grant source. Outputs are combinational from state and inputs.
- Request definition: reqN = mN_cyc_i & mN_stb_i.
- IDLE transitions:
  - Exactly one request: go to GRANTN next cycle.
  - Both requesting: grant the master named by the priority pointer.
  - Arbitration latency is 1 cycle: request at cycle N gives s_cyc_o=1 at N+1.
- Outputs in GRANTN:
  - s_cyc_o = mN_cyc_i and s_stb_o = mN_stb_i.
  - s_we_o, s_wstrb_o, s_addr_o, s_data_o are muxed from mN.
  - mN_ack_o = s_ack_i and mN_data_o = s_data_i, with no register on the return path.
- Outputs of the non-granted master: ack=0 and err=0. Its data_o is driven with s_data_i; it is only qualified by ack.
- In IDLE: s_cyc_o=0, s_stb_o=0, and the muxed address/data are 0.
- Completion: when s_ack_i=1 in GRANTN, the priority pointer moves to the other master. The next state is chosen from requests sampled that same cycle:
  - Other master requesting: go to GRANT(other). This is a direct handoff with no IDLE bubble.
  - Only mN requesting: stay in GRANTN, giving back-to-back accesses.
  - Neither requesting: go to IDLE.
- Abort: mN_cyc_i dropping while in GRANTN means IDLE next cycle. A late s_ack_i in that cycle is not forwarded. The priority pointer is unchanged.
- Timeout counter:
  - Clears on grant entry and on every s_ack_i.
  - Increments each GRANTN cycle with s_stb_o=1 and s_ack_i=0.
- Timeout firing: when the counter reaches TIMEOUT_CYCLES-1 and s_ack_i=0:
  - mN_err_o is a 1-cycle pulse.
  - s_cyc_o stays asserted that cycle, then the arbiter goes to IDLE.
  - The priority pointer moves to the other master.
- ack versus timeout: if s_ack_i coincides with the timeout cycle, ack wins and err stays 0.
- Invariants:
  - ack and err are never both 1.
  - At most one master sees ack in any cycle.
  - grant_o is always one-hot or zero.
- Reset mid-transaction: all outputs drop immediately (asynchronous). Any outstanding slave ack after release is ignored because the state is IDLE.

Decomposition:
- Shared package wb_pkg holds:
  - typedef arb_state_t {IDLE, GRANT0, GRANT1}
  - typedef wb_req_t (cyc, stb, we, wstrb, addr, data)
  - typedef wb_rsp_t (data, ack, err)
  - constant WB_DEFAULT_TIMEOUT = 1024
- One natural sub-module: wb_timeout_counter, which holds the counter, the clear/increment logic and the expired flag.
- The arbiter FSM and the muxes stay in wb_bus_arbiter.

Test Plan:
- Single m0 read at addr 0x0000_0010, slave acks 2 cycles later with 0xDEAD_BEEF:
  - s_cyc_o rises 1 cycle after the request.
  - m0_ack_o=1 with m0_data_o=0xDEAD_BEEF in the ack cycle.
  - m1_ack_o stays 0.
- m0 and m1 request in the same cycle from reset:
  - m0 is granted first.
  - On m0's ack, grant_o goes from 01 to 10 on the next edge with no IDLE cycle.
  - m1 write of 0x1234_5678, wstrb=0xF, reaches s_data_o and s_wstrb_o.
- Both masters request continuously for 6 transactions, slave acks every cycle it is strobed:
  - Grants strictly alternate 0,1,0,1,0,1.
  - Each master receives exactly 3 acks.
- TIMEOUT_CYCLES=8, m1 request with s_ack_i held 0:
  - m1_err_o pulses for exactly 1 cycle, 8 cycles after grant.
  - State is IDLE next cycle.
  - A subsequent m0 request is served normally.
- m0 drops cyc 1 cycle after grant, and the slave acks in that same cycle:
  - m0_ack_o=0.
  - Arbiter returns to IDLE.
  - A pending m1 request is granted the following cycle.
- rst_n pulled low for 1 cycle mid-grant while s_ack_i=0:
  - s_cyc_o, s_stb_o and grant_o go to 0 asynchronously, before the next clock edge.
  - After release, m0 has priority again.
